// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  // M-extension funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // funct7 the decoder matches to steer OP instructions to this unit
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide step,
// operating on unsigned magnitudes.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [XLEN-1:0]   opnd,    // multiplicand (mul) or divisor (div)
  input  logic [2*XLEN-1:0] prod_i,
  input  logic [XLEN:0]     rem_i,
  input  logic [XLEN-1:0]   quot_i,
  output logic [2*XLEN-1:0] prod_o,
  output logic [XLEN:0]     rem_o,
  output logic [XLEN-1:0]   quot_o
);

  logic [XLEN:0]   addend;
  logic [XLEN:0]   sum;
  logic [XLEN+1:0] trial;
  logic [XLEN+1:0] diff;

  // Compute the next iteration; the inactive side passes through unchanged
  always_comb begin
    prod_o = prod_i;
    rem_o  = rem_i;
    quot_o = quot_i;
    // multiplier bits sit in the low half and are consumed LSB first
    addend = prod_i[0] ? {1'b0, opnd} : '0;
    sum    = {1'b0, prod_i[2*XLEN-1:XLEN]} + addend;
    // dividend bits are shifted out of the quotient register MSB first
    trial  = {rem_i, quot_i[XLEN-1]};
    diff   = trial - {2'b00, opnd};
    if (is_div) begin
      if (!diff[XLEN+1]) begin
        rem_o  = diff[XLEN:0];
        quot_o = {quot_i[XLEN-2:0], 1'b1};
      end else begin
        rem_o  = trial[XLEN:0];
        quot_o = {quot_i[XLEN-2:0], 1'b0};
      end
    end else begin
      prod_o = {sum, prod_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: FSM, sign handling, special-case
// shortcuts and the held result register.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, div_ovf;
  logic [2*XLEN-1:0] prod_step;
  logic [XLEN:0]     rem_step;
  logic [XLEN-1:0]   quot_step;
  logic [XLEN-1:0]   res_sel;

  // Operand signedness and magnitudes for the incoming request
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin a_signed = 1'b1; b_signed = 1'b1; end
      F3_MULHSU:                       a_signed = 1'b1;
      default: ;
    endcase
    a_neg    = a_signed & rs1[XLEN-1];
    b_neg    = b_signed & rs2[XLEN-1];
    abs_a    = a_neg ? -rs1 : rs1;
    abs_b    = b_neg ? -rs2 : rs2;
    div_zero = funct3[2] && (rs2 == '0);
    div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (rs1 == MIN_NEG) && (rs2 == ALL_ONES);
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div (f3_q[2]),
    .opnd   (opnd_q),
    .prod_i (prod_q),
    .rem_i  (rem_q),
    .quot_i (quot_q),
    .prod_o (prod_step),
    .rem_o  (rem_step),
    .quot_o (quot_step)
  );

  // Pick the architectural result from the (already sign-fixed) datapath
  always_comb begin
    case (f3_q)
      F3_MUL:                      res_sel = prod_q[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_sel = prod_q[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             res_sel = quot_q;
      default:                     res_sel = rem_q[XLEN-1:0];
    endcase
  end

  // Next-state and datapath control; kill always returns to IDLE silently
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    opnd_d    = opnd_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE) && !kill;
    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          f3_d      = funct3;
          cnt_d     = '0;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (funct3[2]) begin
            opnd_d = abs_b;
            quot_d = abs_a;
            rem_d  = '0;
            if (div_zero) begin
              quot_d  = ALL_ONES;
              rem_d   = {1'b0, rs1};
              state_d = DONE;
            end else if (div_ovf) begin
              quot_d  = MIN_NEG;
              rem_d   = '0;
              state_d = DONE;
            end else begin
              state_d = CALC;
            end
          end else begin
            opnd_d  = abs_a;
            prod_d  = {{XLEN{1'b0}}, abs_b};
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          prod_d = prod_step;
          rem_d  = rem_step;
          quot_d = quot_step;
          if (cnt_q == CW'(XLEN - 1)) begin
            cnt_d   = '0;
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FIX: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          prod_d  = neg_res_q ? -prod_q : prod_q;
          quot_d  = neg_res_q ? -quot_q : quot_q;
          rem_d   = {1'b0, (neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0])};
          state_d = DONE;
        end
      end
      DONE: begin
        if (!kill) result_d = res_sel;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result is visible during the done pulse, then held in result_q
  assign result = done ? res_sel : result_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      opnd_q    <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      opnd_q    <= opnd_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus kill/ignore/reset sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        kill = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Issue one op at the current (post-negedge) time; returns after the first idle cycle
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int poke_cyc, output logic [31:0] res, output int lat,
                        output int busy_bad);
    int cyc;
    bit got;
    funct3 = f3; rs1 = a; rs2 = b; start = 1'b1;
    res = '0; lat = -1; busy_bad = 0; got = 0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!got && cyc <= 60) begin
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        got = 1; res = result; lat = cyc;
      end else begin
        if (cyc == poke_cyc) begin
          start = 1'b1; funct3 = F3_DIV; rs1 = 32'd9; rs2 = 32'd0;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    @(negedge clk);
    if (busy !== 1'b0) busy_bad++;
    $display("op f3=%0d a=%h b=%h result=%h latency=%0d", f3, a, b, res, lat);
  endtask

  initial begin
    logic [31:0] res;
    int lat, bb, dc0;
    logic [31:0] prior;

    vecs[0]  = '{F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    vecs[1]  = '{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34};
    vecs[2]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    vecs[3]  = '{F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    vecs[4]  = '{F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    vecs[5]  = '{F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    vecs[6]  = '{F3_DIVU,   32'd100,      32'd7,        32'd14,       34};
    vecs[7]  = '{F3_REMU,   32'd100,      32'd7,        32'd2,        34};
    vecs[8]  = '{F3_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{F3_REM,    32'd5,        32'd0,        32'd5,        1};
    vecs[10] = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[12] = '{F3_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        34};
    vecs[13] = '{F3_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 34};
    vecs[14] = '{F3_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    vecs[15] = '{F3_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        34};

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);

    // Vector table, issued back-to-back
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, 0, res, lat, bb);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_busy", i), bb, 32'd0);
      check($sformatf("vec%0d_held", i), result, vecs[i].exp);
    end
    prior = vecs[NV-1].exp;

    // Kill in cycle 10 of a multiply; restart in cycle 11
    dc0 = done_cnt;
    funct3 = F3_MUL; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", {31'd0, busy}, 32'd0);
    check("kill_result", result, prior);
    check("kill_no_done", done_cnt - dc0, 32'd0);
    $display("kill sequence busy=%b result=%h", busy, result);
    run_op(F3_DIVU, 32'd100, 32'd7, 0, res, lat, bb);
    check("after_kill_result", res, 32'd14);
    check("after_kill_latency", lat, 32'd34);
    check("after_kill_done_count", done_cnt - dc0, 32'd1);

    // A start in cycle 20 of a running op is ignored
    dc0 = done_cnt;
    run_op(F3_MUL, 32'd6, 32'd7, 20, res, lat, bb);
    repeat (3) @(negedge clk);
    check("ignore_result", res, 32'd42);
    check("ignore_latency", lat, 32'd34);
    check("ignore_busy", bb, 32'd0);
    check("ignore_done_count", done_cnt - dc0, 32'd1);
    check("ignore_idle", {31'd0, busy}, 32'd0);

    // Kill beats a simultaneous start in IDLE
    dc0 = done_cnt;
    funct3 = F3_DIV; rs1 = 32'd5; rs2 = 32'd0; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_kill_busy", {31'd0, busy}, 32'd0);
    check("idle_kill_done_count", done_cnt - dc0, 32'd0);
    check("idle_kill_result", result, 32'd42);
    $display("idle kill busy=%b result=%h", busy, result);

    // Asynchronous reset mid-CALC
    dc0 = done_cnt;
    funct3 = F3_MUL; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    $display("async reset busy=%b done=%b result=%h", busy, done, result);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_no_done", done_cnt - dc0, 32'd0);
    run_op(F3_MUL, 32'd7, 32'hFFFFFFFD, 0, res, lat, bb);
    check("post_rst_result", res, 32'hFFFFFFEB);
    check("post_rst_latency", lat, 32'd34);
    check("post_rst_busy", bb, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
